// File: rtl/sfx_voice.sv
// sfx_voice -- single square-wave sound-effect voice with optional linear
// frequency sweep and a length limit counted in sweep ticks.
//
// Ports:
//   clk          audio-domain clock
//   rst_n        asynchronous active-low reset
//   play         one-cycle pulse: start/restart the sound (ignored if base_period == 0)
//   stop         one-cycle pulse: abort the sound
//   base_period  initial half-period in clk cycles (sampled on play)
//   delta        half-period change per sweep tick (sampled on play)
//   sweep_down   1: subtract delta per tick, 0: add it (sampled on play)
//   length       duration in sweep ticks, 0 = until stop (sampled on play)
//   out          square-wave audio bit (registered)
//   busy         high while playing (registered)
//
// Configuration macro: SFX_VOICE_SWEEP_EN -- when defined, the half-period
// sweeps by delta every tick (saturating at 1 and at all-ones); when
// undefined, there is no sweep logic and delta/sweep_down are ignored.

module sfx_voice #(
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned LEN_WIDTH    = 12,
  parameter int unsigned TICK_DIV     = 100_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    play,
  input  logic                    stop,
  input  logic [PERIOD_WIDTH-1:0] base_period,
  input  logic [15:0]             delta,
  input  logic                    sweep_down,
  input  logic [LEN_WIDTH-1:0]    length,
  output logic                    out,
  output logic                    busy
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t                  state, state_next;
  logic                    out_next, busy_next;
  logic [PERIOD_WIDTH-1:0] half_cnt, half_cnt_next;
  logic [PRESC_W-1:0]      presc, presc_next;
  logic [LEN_WIDTH-1:0]    tick_cnt, tick_cnt_next;
  logic [PERIOD_WIDTH-1:0] cur_period, cur_period_next;
  logic [LEN_WIDTH-1:0]    len_r, len_next;

  logic                    start;
  logic                    half_wrap;
  logic                    sweep_tick;
  logic [LEN_WIDTH-1:0]    tick_inc;
  logic                    expire;

`ifdef SFX_VOICE_SWEEP_EN
  localparam int unsigned SUM_W = ((PERIOD_WIDTH > 16) ? PERIOD_WIDTH : 16) + 1;

  logic [15:0]             delta_r, delta_next;
  logic                    sweep_down_r, sweep_down_next;
  logic [SUM_W-1:0]        cur_ext, delta_ext, sum_ext;
  logic [PERIOD_WIDTH-1:0] swept_period;

  // Saturating sweep: never reaches 0 going down, clamps at all-ones going up.
  always_comb begin
    cur_ext      = SUM_W'(cur_period);
    delta_ext    = SUM_W'(delta_r);
    sum_ext      = cur_ext + delta_ext;
    swept_period = cur_period;
    if (sweep_down_r) begin
      if (cur_ext > delta_ext) swept_period = PERIOD_WIDTH'(cur_ext - delta_ext);
      else                     swept_period = PERIOD_WIDTH'(1);
    end else begin
      if (sum_ext[SUM_W-1:PERIOD_WIDTH] != '0) swept_period = '1;
      else                                     swept_period = PERIOD_WIDTH'(sum_ext);
    end
  end
`else
  logic unused_sweep_inputs;
  assign unused_sweep_inputs = ^{delta, sweep_down};
`endif

  assign start = play && (base_period != '0);

  // ">=" rather than "==" so a period that shrinks below the running count
  // wraps on the very next cycle instead of running the counter all the way round.
  assign half_wrap  = ({1'b0, half_cnt} + (PERIOD_WIDTH + 1)'(1)) >= {1'b0, cur_period};
  assign sweep_tick = (presc == PRESC_LAST);
  assign tick_inc   = tick_cnt + LEN_WIDTH'(1);
  assign expire     = sweep_tick && (len_r != '0) && (tick_inc == len_r);

  always_comb begin
    state_next      = state;
    out_next        = out;
    half_cnt_next   = half_cnt;
    presc_next      = presc;
    tick_cnt_next   = tick_cnt;
    cur_period_next = cur_period;
    len_next        = len_r;
`ifdef SFX_VOICE_SWEEP_EN
    delta_next      = delta_r;
    sweep_down_next = sweep_down_r;
`endif

    if (start) begin
      // play wins over stop and over a simultaneous length expiry
      cur_period_next = base_period;
      len_next        = length;
`ifdef SFX_VOICE_SWEEP_EN
      delta_next      = delta;
      sweep_down_next = sweep_down;
`endif
      half_cnt_next   = '0;
      presc_next      = '0;
      tick_cnt_next   = '0;
      out_next        = 1'b0;
      state_next      = PLAY;
    end else if (state == PLAY) begin
      if (stop) begin
        state_next = IDLE;
        out_next   = 1'b0;
      end else begin
        if (half_wrap) begin
          half_cnt_next = '0;
          out_next      = ~out;
        end else begin
          half_cnt_next = half_cnt + PERIOD_WIDTH'(1);
        end

        if (sweep_tick) begin
          presc_next    = '0;
          tick_cnt_next = tick_inc;
`ifdef SFX_VOICE_SWEEP_EN
          cur_period_next = swept_period;
`endif
          if (expire) begin
            state_next = IDLE;
            out_next   = 1'b0;
          end
        end else begin
          presc_next = presc + PRESC_W'(1);
        end
      end
    end

    busy_next = (state_next == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out          <= 1'b0;
      busy         <= 1'b0;
      half_cnt     <= '0;
      presc        <= '0;
      tick_cnt     <= '0;
      cur_period   <= '0;
      len_r        <= '0;
`ifdef SFX_VOICE_SWEEP_EN
      delta_r      <= '0;
      sweep_down_r <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      out          <= out_next;
      busy         <= busy_next;
      half_cnt     <= half_cnt_next;
      presc        <= presc_next;
      tick_cnt     <= tick_cnt_next;
      cur_period   <= cur_period_next;
      len_r        <= len_next;
`ifdef SFX_VOICE_SWEEP_EN
      delta_r      <= delta_next;
      sweep_down_r <= sweep_down_next;
`endif
    end
  end

endmodule

// File: tb/tb_sfx_voice.sv
// tb_sfx_voice -- directed self-checking bench for sfx_voice with
// PERIOD_WIDTH = 8, LEN_WIDTH = 4, TICK_DIV = 10. Sweep-dependent
// expectations follow SFX_VOICE_SWEEP_EN.

module tb_sfx_voice;

  logic       clk;
  logic       rst_n;
  logic       play;
  logic       stop;
  logic [7:0] base_period;
  logic [15:0] delta;
  logic       sweep_down;
  logic [3:0] length;
  logic       out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  sfx_voice #(
    .PERIOD_WIDTH(8),
    .LEN_WIDTH(4),
    .TICK_DIV(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .play(play),
    .stop(stop),
    .base_period(base_period),
    .delta(delta),
    .sweep_down(sweep_down),
    .length(length),
    .out(out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] bp, input logic [15:0] d, input logic sd,
                       input logic [3:0] len);
    base_period = bp;
    delta       = d;
    sweep_down  = sd;
    length      = len;
    play        = 1'b1;
    step();
    play        = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Scenario 2 expected out after edge k (base 4, delta 2, up).
  function automatic logic s2_out(input int k);
`ifdef SFX_VOICE_SWEEP_EN
    int n;
    n = int'(k >= 4) + int'(k >= 8) + int'(k >= 14) + int'(k >= 20) + int'(k >= 28);
    return logic'(n % 2);
`else
    return logic'((k / 4) % 2);
`endif
  endfunction

  // Scenario 3 expected out after edge k (base 3, delta 5, down).
  function automatic logic s3_out(input int k);
`ifdef SFX_VOICE_SWEEP_EN
    int n;
    if (k <= 10) n = int'(k >= 3) + int'(k >= 6) + int'(k >= 9);
    else         n = 3 + (k - 10);
    return logic'(n % 2);
`else
    return logic'((k / 3) % 2);
`endif
  endfunction

`ifdef SFX_VOICE_SWEEP_EN
  localparam int S4_T = 255;
`else
  localparam int S4_T = 250;
`endif

  initial begin
    play        = 1'b0;
    stop        = 1'b0;
    base_period = '0;
    delta       = '0;
    sweep_down  = 1'b0;
    length      = '0;
    rst_n       = 1'b0;
    #2;
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Scenario 1: fixed period 4, length 3 ticks -> 30 busy cycles
    start(8'd4, 16'd0, 1'b0, 4'd3);
    for (int k = 0; k < 30; k++) begin
      check($sformatf("s1_busy_%0d", k), busy, 1);
      check($sformatf("s1_out_%0d", k), out, (k / 4) % 2);
      step();
    end
    check("s1_end_busy", busy, 0);
    check("s1_end_out", out, 0);

    // Scenario 2 / 8: upward sweep, stopped at cycle 35
    start(8'd4, 16'd2, 1'b0, 4'd0);
    for (int k = 0; k < 35; k++) begin
      check($sformatf("s2_busy_%0d", k), busy, 1);
      check($sformatf("s2_out_%0d", k), out, s2_out(k));
      if (k == 34) stop = 1'b1;
      step();
      stop = 1'b0;
    end
    check("s2_stop_busy", busy, 0);
    check("s2_stop_out", out, 0);
    halt();
    check("stop_in_idle_busy", busy, 0);

    // Scenario 3: downward sweep saturating at 1
    start(8'd3, 16'd5, 1'b1, 4'd0);
    for (int k = 0; k < 25; k++) begin
      check($sformatf("s3_out_%0d", k), out, s3_out(k));
      step();
    end
    check("s3_busy", busy, 1);
    halt();
    check("s3_stop_busy", busy, 0);

    // Scenario 4: upward sweep saturating at 255
    start(8'd250, 16'd10, 1'b0, 4'd0);
    for (int k = 0; k <= 2 * S4_T; k++) begin
      if (k == S4_T - 1)     check("s4_pre_first", out, 0);
      if (k == S4_T)         check("s4_first", out, 1);
      if (k == 2 * S4_T - 1) check("s4_pre_second", out, 1);
      if (k == 2 * S4_T)     check("s4_second", out, 0);
      step();
    end
    halt();

    // Scenario 5: play + stop together while busy -> restart
    start(8'd4, 16'd0, 1'b0, 4'd3);
    repeat (13) step();
    check("s5_pre_out", out, 1);
    base_period = 8'd5;
    length      = 4'd2;
    play        = 1'b1;
    stop        = 1'b1;
    step();
    play        = 1'b0;
    stop        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("s5_busy_%0d", k), busy, 1);
      check($sformatf("s5_out_%0d", k), out, (k / 5) % 2);
      step();
    end
    check("s5_end_busy", busy, 0);

    // Length expiry coinciding with play -> restart wins
    start(8'd4, 16'd0, 1'b0, 4'd1);
    repeat (9) step();
    base_period = 8'd6;
    length      = 4'd2;
    play        = 1'b1;
    step();
    play        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("exp_busy_%0d", k), busy, 1);
      check($sformatf("exp_out_%0d", k), out, (k / 6) % 2);
      step();
    end
    check("exp_end_busy", busy, 0);

    // Scenario 6: base_period 0 ignored, in idle and while playing
    base_period = 8'd0;
    play        = 1'b1;
    step();
    play        = 1'b0;
    check("s6_idle_busy", busy, 0);
    check("s6_idle_out", out, 0);
    start(8'd4, 16'd0, 1'b0, 4'd0);
    step();
    step();
    base_period = 8'd0;
    play        = 1'b1;
    step();
    play        = 1'b0;
    check("s6_play_busy", busy, 1);
    step();
    check("s6_play_out", out, 1);
    halt();

    // Scenario 7: asynchronous reset mid-sound
    start(8'd2, 16'd0, 1'b0, 4'd0);
    repeat (3) step();
    check("s7_pre_out", out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s7_async_out", out, 0);
    check("s7_async_busy", busy, 0);
    step();
    check("s7_held_out", out, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("s7_wait_busy_%0d", k), busy, 0);
      check($sformatf("s7_wait_out_%0d", k), out, 0);
    end
    start(8'd2, 16'd0, 1'b0, 4'd1);
    step();
    step();
    check("s7_replay_out", out, 1);
    check("s7_replay_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_voice.md
SFX_VOICE -- requirements
Module: sfx_voice

Interface
REQ-001 Parameter PERIOD_WIDTH, default 24, width of the half-period values in clk cycles.
REQ-002 Parameter LEN_WIDTH, default 12, width of the length value in sweep ticks.
REQ-003 Parameter TICK_DIV, default 100_000, clk cycles per sweep tick; legal range is >= 1.
REQ-004 clk  input  1  the single clock, which is the audio clock domain.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 play  input  1  one-cycle pulse that starts or restarts the sound.
REQ-007 stop  input  1  one-cycle pulse that aborts the sound.
REQ-008 base_period  input  PERIOD_WIDTH  initial half-period in clk cycles; sampled on play.
REQ-009 delta  input  16  unsigned half-period change per sweep tick; sampled on play.
REQ-010 sweep_down  input  1  1 subtracts delta each tick, 0 adds it; sampled on play.
REQ-011 length  input  LEN_WIDTH  sound duration in sweep ticks, where 0 means play until stop; sampled on play.
REQ-012 out  output  1  square-wave audio bit.
REQ-013 busy  output  1  high while in the PLAY state.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and PLAY.
REQ-015 In IDLE, out SHALL be 0 and busy SHALL be 0.
REQ-016 play with base_period != 0 SHALL, on that edge, latch all sampled inputs into internal registers.
REQ-017 On that same edge it SHALL also clear the half-period counter, tick prescaler and tick counter, set out to 0, and enter PLAY.
REQ-018 busy SHALL be high from the cycle after play.
REQ-019 play with base_period == 0 SHALL be ignored, leaving the state unchanged.
REQ-020 In PLAY, the half-period counter SHALL increment every cycle.
REQ-021 When the half-period counter reaches cur_period-1, it SHALL wrap to 0 and out SHALL toggle, so the first toggle comes cur_period cycles after entry.
REQ-022 The tick prescaler SHALL count 0..TICK_DIV-1 in PLAY, and each wrap SHALL be one sweep tick.
REQ-023 On each sweep tick, the tick counter SHALL increment.
REQ-024 If the latched length != 0 and the tick counter reaches length, the block SHALL return to IDLE on that edge, with out forced to 0.
REQ-025 If the latched length == 0, the block SHALL never end on its own.
REQ-026 With sweep_down = 0, each sweep tick SHALL set cur_period to cur_period + delta, saturating at 2^PERIOD_WIDTH-1.
REQ-027 With sweep_down = 1, each sweep tick SHALL set cur_period to cur_period - delta, saturating at 1 (never 0).
REQ-028 A new cur_period SHALL take effect at the next half-period counter comparison.
REQ-029 If the half-period counter is already >= the new value, the counter SHALL wrap and out SHALL toggle on the next cycle.
REQ-030 stop in PLAY SHALL return to IDLE on that edge.
REQ-031 stop in IDLE SHALL have no effect.
REQ-032 play while busy SHALL restart per REQ-016 to REQ-017, discarding the old sound.
REQ-033 play and stop in the same cycle SHALL be resolved with play taking priority.
REQ-034 A length expiry and play in the same cycle SHALL be resolved with play taking priority, restarting the sound.
REQ-035 All state SHALL be registered, and out and busy SHALL be flop outputs with no combinational input-to-output paths.

Reset
REQ-036 Asserting rst_n low SHALL immediately force IDLE, out = 0, busy = 0, and all counters and latched registers to 0.
REQ-037 Reset asserted mid-sound SHALL abort the sound, with no toggle after reset assertion.
REQ-038 After rst_n deassertion, the block SHALL wait for a new play pulse.

Configuration
REQ-039 Macro SFX_VOICE_SWEEP_EN defined: the frequency sweep SHALL operate per REQ-026 to REQ-029.
REQ-040 Macro SFX_VOICE_SWEEP_EN undefined: there SHALL be no sweep logic, cur_period SHALL stay at the latched base_period, and delta and sweep_down SHALL be ignored.
REQ-041 Length and tick counting SHALL behave identically with or without SFX_VOICE_SWEEP_EN.

Verification (TICK_DIV = 10, PERIOD_WIDTH = 8, LEN_WIDTH = 4, SFX_VOICE_SWEEP_EN defined unless stated)
REQ-042 Scenario 1: play with base_period = 4, delta = 0, length = 3 -> out toggles every 4 cycles, busy is high for exactly 30 cycles, then out = 0 and busy = 0.
REQ-043 Scenario 2: play with base_period = 4, delta = 2, sweep_down = 0, length = 0 -> the half-period is 4, 6, 8 in successive 10-cycle ticks; stop at cycle 35 -> IDLE next edge, and busy stays high until then.
REQ-044 Scenario 3: play with base_period = 3, delta = 5, sweep_down = 1 -> the half-period saturates at 1 after the first tick, out toggles every cycle, and no zero-period lockup occurs.
REQ-045 Scenario 4: play with base_period = 250, delta = 10, sweep_down = 0 -> the half-period saturates at 255.
REQ-046 Scenario 5: play and stop asserted together while busy -> the sound restarts, counters are cleared, and busy stays high.
REQ-047 Scenario 6: play with base_period = 0 -> busy stays 0.
REQ-048 Scenario 7: rst_n pulsed low mid-sound -> out and busy are 0 asynchronously, before the next clk edge.
REQ-049 Scenario 8: Scenario 2 rerun with SFX_VOICE_SWEEP_EN undefined -> the period stays 4 throughout.
